// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory responder.
package mem_pkg;

    // RV32I load/store size and sign encodings carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wait-state counter width; WAIT_CYCLES tops out at 15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } mem_state_t;

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a RAM word and extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then sign or zero extension by funct3
    always_comb begin
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            F3_W:    load_data = word;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, optional wait states,
// one access cycle, then a single-cycle response pulse.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One bit wider than the address so DEPTH*4 never wraps
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH) << 2;

    logic [31:0] ram [DEPTH];

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              f3_ok, misaligned, out_of_range, acc_err;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word, load_data;
    logic [3:0]        wr_be;
    logic [31:0]       wr_word;
    logic              wr_en;

    assign idx     = addr_q[IDX_W+1:2];
    assign rd_word = ram[idx];

    mem_load_align u_align (
        .word      (rd_word),
        .lane      (addr_q[1:0]),
        .funct3    (f3_q),
        .load_data (load_data)
    );

    // Legality of the latched request: encoding, alignment, range
    always_comb begin
        f3_ok      = 1'b1;
        misaligned = 1'b0;
        case (f3_q)
            F3_B:         f3_ok = 1'b1;
            F3_BU:        f3_ok = !we_q;
            F3_H: begin
                misaligned = addr_q[0];
            end
            F3_HU: begin
                f3_ok      = !we_q;
                misaligned = addr_q[0];
            end
            F3_W:         misaligned = |addr_q[1:0];
            default:      f3_ok = 1'b0;
        endcase
        out_of_range = {1'b0, addr_q} >= LIMIT;
        acc_err      = !f3_ok || misaligned || out_of_range;
    end

    // Store lane enables and replicated data so any lane can pick its byte
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_word = wdata_q;
            end
        endcase
        wr_en = (state_q == ACCESS) && we_q && !acc_err;
    end

    // Next-state and registered-output computation for the request FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    f3_d        = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ACCESS;
            end
            ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = acc_err;
                rsp_rdata_d = (acc_err || we_q) ? 32'h0 : load_data;
                busy_d      = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // FSM and output registers; reset drops any in-flight request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM write on the exit edge of ACCESS; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) ram[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (0 and 3 wait states),
// a byte-array reference model, per-cycle compare, and directed checks.
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int W0    = 0;
    localparam int W1    = 3;

    logic        clk;
    logic        rst_l  [2];
    logic        v      [2];
    logic        we     [2];
    logic [2:0]  f3     [2];
    logic [31:0] addr   [2];
    logic [31:0] wd     [2];
    logic        rdy    [2];
    logic        rv     [2];
    logic [31:0] rdata  [2];
    logic        err    [2];
    logic        bsy    [2];

    int total = 0;
    int bad   = 0;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0), .ADDR_W(32)) dut0 (
        .clk(clk), .rst(rst_l[0]), .req_valid(v[0]), .req_ready(rdy[0]),
        .req_we(we[0]), .req_funct3(f3[0]), .req_addr(addr[0]), .req_wdata(wd[0]),
        .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .rsp_err(err[0]), .busy(bsy[0]));

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst_l[1]), .req_valid(v[1]), .req_ready(rdy[1]),
        .req_we(we[1]), .req_funct3(f3[1]), .req_addr(addr[1]), .req_wdata(wd[1]),
        .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .rsp_err(err[1]), .busy(bsy[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // k = cycles since acceptance (0 = idle); response appears at k = W+2
    int          k      [2] = '{0, 0};
    logic        m_we   [2];
    logic [2:0]  m_f3   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] e_data [2];
    logic        e_err  [2];
    logic [7:0]  mm     [2][256];

    task automatic model_access(input int i);
        int          n;
        logic        legal;
        logic [31:0] a, val;
        a     = m_addr[i];
        n     = 1 << m_f3[i][1:0];
        legal = m_we[i] ? (m_f3[i] inside {3'd0, 3'd1, 3'd2})
                        : (m_f3[i] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal || (a % n) != 0 || a >= DEPTH * 4) begin
            e_err[i]  = 1'b1;
            e_data[i] = 32'h0;
        end else if (m_we[i]) begin
            for (int b = 0; b < n; b++) mm[i][a + b] = m_wd[i][8*b +: 8];
            e_err[i]  = 1'b0;
            e_data[i] = 32'h0;
        end else begin
            val = 32'h0;
            for (int b = 0; b < n; b++) val[8*b +: 8] = mm[i][a + b];
            if (!m_f3[i][2] && n == 1 && val[7])  val = val | 32'hFFFF_FF00;
            if (!m_f3[i][2] && n == 2 && val[15]) val = val | 32'hFFFF_0000;
            e_err[i]  = 1'b0;
            e_data[i] = val;
        end
    endtask

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_l[i]) k[i] = 0;
            else if (k[i] == 0) begin
                if (v[i]) begin
                    m_we[i] = we[i]; m_f3[i] = f3[i];
                    m_addr[i] = addr[i]; m_wd[i] = wd[i];
                    k[i] = 1;
                end
            end else if (k[i] == wc(i) + 1) begin
                model_access(i);
                k[i] = k[i] + 1;
            end else if (k[i] == wc(i) + 2) k[i] = 0;
            else k[i] = k[i] + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic [2:0] af, ef;
            bit ok;
            af = {rdy[i], bsy[i], rv[i]};
            if (!rst_l[i]) begin
                ef = 3'b100;
                ok = (af == ef) && rdata[i] == 32'h0 && err[i] == 1'b0;
                check(ok, $sformatf("reset outputs inst%0d", i),
                      {27'h0, af, err[i], rdata[i]}, {27'h0, ef, 1'b0, 32'h0});
            end else begin
                ef = {k[i] == 0, k[i] >= 1 && k[i] <= wc(i) + 1, k[i] == wc(i) + 2};
                ok = (af == ef) && (!ef[0] || (rdata[i] == e_data[i] && err[i] == e_err[i]));
                check(ok, $sformatf("cycle inst%0d k=%0d", i, k[i]),
                      {27'h0, af, err[i], rdata[i]}, {27'h0, ef, e_err[i], e_data[i]});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int i, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d, output time t_acc);
        int n;
        bit ok;
        we[i] = w; f3[i] = f; addr[i] = a; wd[i] = d; v[i] = 1'b1;
        n = 0; ok = 0;
        while (n < 40 && !ok) begin
            @(negedge clk);
            if (rdy[i]) ok = 1; else n++;
        end
        check(ok, $sformatf("accept inst%0d", i), 64'(n), 64'd0);
        t_acc = 0;
        if (!ok) begin
            v[i] = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        #1;
        // later changes to the request fields must be ignored
        v[i] = 1'b0; we[i] = 1'($urandom); f3[i] = 3'($urandom);
        addr[i] = $urandom; wd[i] = $urandom;
    endtask

    task automatic txn(input int i, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] xd, input logic xe, input string name);
        time t;
        int  lat;
        issue(i, w, f, a, d, t);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv[i] && lat < 40);
        check(lat == wc(i) + 2, {name, " latency"}, 64'(lat), 64'(wc(i) + 2));
        check(rv[i] && rdata[i] == xd && err[i] == xe, name,
              {31'h0, err[i], rdata[i]}, {31'h0, xe, xd});
    endtask

    initial begin
        time ta, tb;
        int  cnt;
        for (int i = 0; i < 2; i++) begin
            rst_l[i] = 1'b1; v[i] = 1'b0; we[i] = 1'b0; f3[i] = 3'b0;
            addr[i] = 32'h0; wd[i] = 32'h0;
        end
        #1;
        rst_l[0] = 1'b0; rst_l[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check(rdy[1] == 1'b1 && bsy[1] == 1'b0 && rv[1] == 1'b0, "reset state",
              {61'h0, rdy[1], bsy[1], rv[1]}, 64'b100);
        rst_l[0] = 1'b1; rst_l[1] = 1'b1;

        // round trip, no wait states
        txn(0, 1, 3'b010, 32'h10, 32'h8081_82F3, 32'h0, 0, "sw 0x10");
        txn(0, 0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFF3, 0, "lb 0x10");
        txn(0, 0, 3'b100, 32'h10, 32'h0, 32'h0000_00F3, 0, "lbu 0x10");
        txn(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8081, 0, "lh 0x12");
        txn(0, 0, 3'b101, 32'h12, 32'h0, 32'h0000_8081, 0, "lhu 0x12");

        // byte-lane merge
        txn(0, 1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 0, "sw 0x20");
        txn(0, 1, 3'b000, 32'h21, 32'hFFFF_FFAA, 32'h0, 0, "sb 0x21");
        txn(0, 1, 3'b001, 32'h22, 32'h1234_BEEF, 32'h0, 0, "sh 0x22");
        txn(0, 0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AA44, 0, "lw 0x20 merged");

        // last in-range word and errors
        txn(0, 1, 3'b010, 32'hFC, 32'hA5A5_5A5A, 32'h0, 0, "sw last word");
        txn(0, 0, 3'b010, 32'hFC, 32'h0, 32'hA5A5_5A5A, 0, "lw last word");
        txn(0, 0, 3'b001, 32'h13, 32'h0, 32'h0, 1, "lh misaligned");
        txn(0, 1, 3'b010, 32'h22, 32'hCAFE_F00D, 32'h0, 1, "sw misaligned");
        txn(0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 1, "lw out of range");
        txn(0, 0, 3'b011, 32'h20, 32'h0, 32'h0, 1, "funct3 011");
        txn(0, 1, 3'b100, 32'h20, 32'hDEAD_0000, 32'h0, 1, "store funct3 100");
        txn(0, 0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AA44, 0, "lw 0x20 after errors");

        // three wait states: seed, then reset during WAIT drops the store
        txn(1, 1, 3'b010, 32'h10, 32'h0102_0304, 32'h0, 0, "w3 sw 0x10");
        txn(1, 0, 3'b010, 32'h10, 32'h0, 32'h0102_0304, 0, "w3 lw 0x10");
        issue(1, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, ta);
        repeat (2) @(posedge clk);
        #1;
        rst_l[1] = 1'b0;
        #1;
        check(rdy[1] == 1'b1 && bsy[1] == 1'b0, "ready right after reset",
              {62'h0, rdy[1], bsy[1]}, 64'b10);
        repeat (2) @(negedge clk);
        #1;
        rst_l[1] = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rv[1]) cnt++;
        end
        check(cnt == 0, "no response after reset", 64'(cnt), 64'd0);
        txn(1, 0, 3'b010, 32'h10, 32'h0, 32'h0102_0304, 0, "w3 lw after dropped sw");

        // back-to-back held request is taken 6 edges after the first
        issue(1, 0, 3'b010, 32'h10, 32'h0, ta);
        issue(1, 0, 3'b100, 32'h11, 32'h0, tb);
        check((tb - ta) == 60, "second acceptance gap", 64'(tb - ta), 64'd60);
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
